// File: rtl/mmm_result_unit.sv
// mmm_result_unit
// -----------------------------------------------------------------------------
// Final stage of a word-serial Montgomery multiplier. Collects the unreduced
// result S (NW = DW/W + 1 words, LSW first) from the last PE. While collecting,
// it computes D = S - M one word at a time with a single W-bit subtractor. One
// DECIDE cycle then selects D when the final borrow is clear (S >= M), or S
// otherwise. The EMIT state streams the selected words out, LSW first, under a
// valid/ready handshake.
//
// Configuration macro: MMM_FINAL_SUB_EN
//   defined   -> conditional final subtraction is active.
//   undefined -> there is no subtractor and no D buffer, and S is passed through
//                unchanged. The FSM, the DECIDE cycle and the latency are the
//                same in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   m          modulus M (DW bits); held stable for the whole transaction
//   in_valid   in_word carries a result word
//   in_word    unreduced result word (W bits), LSW first
//   in_ready   block accepts in_word this cycle (COLLECT state)
//   out_valid  out_word is valid (EMIT state)
//   out_word   reduced result word (W bits), LSW first
//   out_last   marks word NW-1
//   out_ready  downstream accepts out_word
//   busy       high unless in COLLECT with word count 0
// -----------------------------------------------------------------------------
module mmm_result_unit #(
  parameter int DW = 6,
  parameter int W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] m,
  input  logic          in_valid,
  input  logic [W-1:0]  in_word,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_word,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  localparam int NW = DW / W + 1;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NW - 1);

  typedef enum logic [1:0] {
    COLLECT,
    DECIDE,
    EMIT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  s_buf [NW];
  logic          accept;
  logic          emit_hs;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign out_last  = out_valid && (cnt == LAST_K);
  assign busy      = !((state == COLLECT) && (cnt == '0));
  assign accept    = in_valid & in_ready;
  assign emit_hs   = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // NOTE: state_next is assigned a default first, so every path through the
  // case assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && (cnt == LAST_K))  state_next = DECIDE;
      DECIDE:                                  state_next = EMIT;
      EMIT:    if (emit_hs && (cnt == LAST_K)) state_next = COLLECT;
      default:                                 state_next = COLLECT;
    endcase
  end

  // A single word counter indexes both the collect and the emit phases. It
  // wraps to 0 after word NW-1 in each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept || emit_hs) begin
      cnt <= (cnt == LAST_K) ? '0 : cnt + 1'b1;
    end
  end

  // NOTE: the word buffers have no reset. The FSM only reads a slot after it
  // has been written in the current transaction, so clearing them would add
  // nothing.
  always_ff @(posedge clk) begin
    if (accept) s_buf[cnt] <= in_word;
  end

`ifdef MMM_FINAL_SUB_EN
  localparam int MW = NW * W;

  logic [MW-1:0] m_ext;
  logic [W-1:0]  m_k;
  logic [W-1:0]  d_k;
  logic [W-1:0]  d_buf [NW];
  logic          borrow;
  logic          borrow_in;
  logic          borrow_out;
  logic          sel_d;

  // M is zero-extended to NW words so the top word subtracts 0.
  assign m_ext     = MW'(m);
  assign m_k       = m_ext[int'(cnt) * W +: W];
  assign borrow_in = (cnt == '0) ? 1'b0 : borrow;
  // The (W+1)-bit difference is negative exactly when its MSB is set, so that
  // bit is the borrow out of this word.
  assign {borrow_out, d_k} = {1'b0, in_word} - {1'b0, m_k} - {{W{1'b0}}, borrow_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow <= 1'b0;
      sel_d  <= 1'b0;
    end else begin
      if (accept)            borrow <= borrow_out;
      // A clear final borrow means S >= M, so the reduced value is D.
      if (state == DECIDE)   sel_d  <= ~borrow;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) d_buf[cnt] <= d_k;
  end

  assign out_word = out_valid ? (sel_d ? d_buf[cnt] : s_buf[cnt]) : '0;
`else
  // There is no reduction in this build, so the modulus is not used.
  logic unused_m;
  assign unused_m = ^m;

  assign out_word = out_valid ? s_buf[cnt] : '0;
`endif

endmodule

// File: tb/tb_mmm_result_unit.sv
// tb_mmm_result_unit
// -----------------------------------------------------------------------------
// Scoreboard bench for mmm_result_unit (DW=6, W=3, so NW=3).
// For each result it issues, the stimulus side computes the expected reduced
// value with plain integer arithmetic (S - M when S >= M and the final
// subtraction is built in, otherwise S). It pushes the expected words into a
// queue. A monitor on the falling edge pops and compares on every output
// handshake. The monitor also checks first-word latency, that words hold while
// the output is stalled, and that in_ready is low while output is pending.
// -----------------------------------------------------------------------------
module tb_mmm_result_unit;

  localparam int DW = 6;
  localparam int W  = 3;
  localparam int NW = DW / W + 1;
  localparam int SW = NW * W;

  typedef struct {
    logic [W-1:0] word;
    logic         last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] m;
  logic          in_valid;
  logic [W-1:0]  in_word;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_word;
  logic          out_last;
  logic          out_ready;
  logic          busy;

  mmm_result_unit #(.DW(DW), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .m         (m),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  exp_t exp_q[$];
  int   lat_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en;
  bit   rand_ready;
  bit   stall_dir;
  int   stall_cnt;
  int   out_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output-ready driver: a directed 3-cycle stall on word 1, random backpressure,
  // or always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_dir && out_valid && out_idx == 1 && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    bit           in_result;
    bit           hold_valid;
    logic [W-1:0] hold_word;
    logic         hold_last;
    exp_t         e;
    int           a;
    in_result  = 0;
    hold_valid = 0;
    out_idx    = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        in_result  = 0;
        hold_valid = 0;
        out_idx    = 0;
      end else begin
        if (hold_valid) begin
          check("hold_valid", out_valid, 1);
          check("hold_word", out_word, hold_word);
          check("hold_last", out_last, hold_last);
          hold_valid = 0;
        end
        if (out_valid) begin
          check("in_ready_while_emit", in_ready, 0);
          if (!in_result) begin
            in_result = 1;
            if (lat_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL latency: out_valid with no pending result (cycle %0d)", cyc);
            end else begin
              a = lat_q.pop_front();
              check("latency", cyc - a, 2);
            end
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_out: word %0d emitted with empty scoreboard", out_word);
            end else begin
              e = exp_q.pop_front();
              check("out_word", out_word, e.word);
              check("out_last", out_last, e.last);
            end
            if (out_last) begin
              in_result = 0;
              out_idx   = 0;
            end else begin
              out_idx++;
            end
          end else begin
            hold_valid = 1;
            hold_word  = out_word;
            hold_last  = out_last;
          end
        end
      end
    end
  end

  task automatic pulse_rst();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Issue one S with modulus mv. With push set, the expected reduced words and
  // the accept cycle of the last word are queued. With hold set, in_valid stays
  // high after the last word.
  task automatic send_result(input int mv, input int sv, input bit push,
                             input bit hold, input int gap_max);
    int          t;
    bit          sub;
    logic [SW-1:0] s_vec;
    logic [SW-1:0] r_vec;
    exp_t        e;
    s_vec = SW'(sv);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("idle_timeout", in_ready, 1);
      return;
    end
    m = DW'(mv);
`ifdef MMM_FINAL_SUB_EN
    sub = (sv >= mv);
`else
    sub = 1'b0;
`endif
    r_vec = sub ? SW'(sv - mv) : s_vec;
    if (push) begin
      for (int k = 0; k < NW; k++) begin
        e.word = r_vec[k*W +: W];
        e.last = (k == NW - 1);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < NW; k++) begin
      if (k > 0 && gap_max > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_word  = s_vec[k*W +: W];
      if (k > 0) begin
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (!in_ready) begin
          check("accept_timeout", in_ready, 1);
          in_valid = 1'b0;
          return;
        end
      end
      if (k == NW - 1 && push) lat_q.push_back(cyc);
      @(posedge clk);
      #1;
    end
    in_valid = hold;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stimulus
    int mv;
    int sv;
    int t;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_word    = '0;
    m          = '0;
    mon_en     = 1'b1;
    rand_ready = 1'b0;
    stall_dir  = 1'b0;
    stall_cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_word", out_word, 0);
    check("rst_busy", busy, 0);

    // Directed: S=50 -> 7,0,0; S=20 -> 4,2,0; S=M -> 0,0,0
    send_result(43, 50, 1, 0, 0);
    send_result(43, 20, 1, 0, 0);
    send_result(43, 43, 1, 0, 0);
    // Boundaries: S=0 and S=2M-1 at the largest modulus
    send_result(63, 0, 1, 0, 0);
    send_result(63, 125, 1, 0, 0);
    wait_drain();

    // Three-cycle stall on word 1
    stall_cnt = 0;
    stall_dir = 1'b1;
    send_result(43, 50, 1, 0, 0);
    wait_drain();
    stall_dir = 1'b0;
    check("stall_cycles", stall_cnt, 3);

    // Reset after two collected words, then a fresh S=20
    @(negedge clk);
    m = DW'(43);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_word  = 3'd2;
    @(posedge clk);
    #1;
    in_word  = 3'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_mid_collect", busy, 1);
    pulse_rst();
    @(negedge clk);
    check("rst_mid_collect_busy", busy, 0);
    check("rst_mid_collect_in_ready", in_ready, 1);
    send_result(43, 20, 1, 0, 0);
    wait_drain();

    // Reset during EMIT: the partial output must be abandoned
    mon_en = 1'b0;
    send_result(43, 50, 0, 0, 0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("emit_seen", out_valid, 1);
    pulse_rst();
    @(negedge clk);
    check("rst_mid_emit_out_valid", out_valid, 0);
    check("rst_mid_emit_busy", busy, 0);
    mon_en = 1'b1;
    send_result(43, 20, 1, 0, 0);
    wait_drain();

    // Back-to-back with in_valid held high
    send_result(43, 50, 1, 1, 0);
    send_result(43, 20, 1, 0, 0);
    wait_drain();

    // Randomised moduli, operands, input gaps and backpressure
    rand_ready = 1'b1;
    repeat (40) begin
      mv = $urandom_range(1, 63);
      sv = $urandom_range(0, 2 * mv - 1);
      send_result(mv, sv, 1, 1'($urandom_range(0, 1)), 2);
    end
    wait_drain();
    rand_ready = 1'b0;
    check("latency_queue_empty", lat_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
